// File: rtl/rtc_calendar.sv
// rtc_calendar
// Real-time clock/calendar core. A prescaler divides clk down to a one-second
// enable that drives a seconds/minutes/hours/day/month/year counter chain with
// correct month lengths and leap years (years 2000-2099, so every year whose
// two low bits are zero is a leap year). Time is loaded through a validated
// single-cycle set port. An optional hh:mm alarm raises a sticky flag.
//
// Optional feature macro: RTC_ALARM_EN
//   defined   -> alarm comparator and sticky alarm_irq register are built
//   undefined -> alarm inputs are ignored and alarm_irq is tied to 0
//
// Parameters
//   TICKS_PER_SEC : clk cycles per second (>= 2)
//
// Ports
//   clk, rst_n          : system clock, asynchronous active-low reset
//   run                 : 1 = prescaler counts, 0 = prescaler and fields frozen
//   set_valid           : one-cycle load strobe for the set_* fields
//   set_sec .. set_year : load values (year 0-99 = 2000-2099)
//   set_err             : one-cycle pulse after a rejected load
//   sec .. year         : current time/date (registered)
//   sec_tick .. day_tick: one-cycle pulse when the field shows its new value
//   alarm_en, alarm_hour, alarm_min, alarm_clr : alarm control
//   alarm_irq           : sticky alarm flag
module rtc_calendar #(
  parameter int TICKS_PER_SEC = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_valid,
  input  logic [5:0] set_sec,
  input  logic [5:0] set_min,
  input  logic [4:0] set_hour,
  input  logic [4:0] set_day,
  input  logic [3:0] set_month,
  input  logic [6:0] set_year,
  output logic       set_err,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_clr,
  output logic       alarm_irq
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [4:0]    day_q, day_d;
  logic [3:0]    month_q, month_d;
  logic [6:0]    year_q, year_d;
  logic          sec_tick_q, sec_tick_d;
  logic          min_tick_q, min_tick_d;
  logic          hour_tick_q, hour_tick_d;
  logic          day_tick_q, day_tick_d;
  logic          set_err_q, set_err_d;
  logic          set_ok;
  logic          terminal;

  // Days in a month; in 2000-2099 a year is leap exactly when year[1:0]==0.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] len;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  assign terminal = run && (presc_q == PRESC_LAST);

  assign set_ok = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23) &&
                  (set_month >= 4'd1) && (set_month <= 4'd12) &&
                  (set_day >= 5'd1) && (set_day <= month_len(set_month, set_year)) &&
                  (set_year <= 7'd99);

  // Next-state for the prescaler and calendar. An accepted load overrides a
  // coincident terminal count; a rejected load leaves normal counting alone.
  always_comb begin
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    sec_tick_d  = 1'b0;
    min_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;
    set_err_d   = 1'b0;

    if (set_valid && set_ok) begin
      presc_d = '0;
      sec_d   = set_sec;
      min_d   = set_min;
      hour_d  = set_hour;
      day_d   = set_day;
      month_d = set_month;
      year_d  = set_year;
    end else begin
      set_err_d = set_valid;
      if (terminal) begin
        presc_d    = '0;
        sec_tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d      = 6'd0;
          min_tick_d = 1'b1;
          if (min_q == 6'd59) begin
            min_d       = 6'd0;
            hour_tick_d = 1'b1;
            if (hour_q == 5'd23) begin
              hour_d     = 5'd0;
              day_tick_d = 1'b1;
              if (day_q >= month_len(month_q, year_q)) begin
                day_d = 5'd1;
                if (month_q == 4'd12) begin
                  month_d = 4'd1;
                  year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                end else begin
                  month_d = month_q + 4'd1;
                end
              end else begin
                day_d = day_q + 5'd1;
              end
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else if (run) begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= 5'd0;
      day_q       <= 5'd1;
      month_q     <= 4'd1;
      year_q      <= 7'd0;
      sec_tick_q  <= 1'b0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      sec_tick_q  <= sec_tick_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
      day_tick_q  <= day_tick_d;
      set_err_q   <= set_err_d;
    end
  end

`ifdef RTC_ALARM_EN
  logic alarm_irq_q, alarm_irq_d;

  // Sticky alarm: only a counted minute change can set it (min_tick_d is
  // never raised by a load), and a set beats a simultaneous clear.
  always_comb begin
    alarm_irq_d = alarm_irq_q;
    if (alarm_clr) begin
      alarm_irq_d = 1'b0;
    end
    if (min_tick_d && alarm_en && (hour_d == alarm_hour) && (min_d == alarm_min)) begin
      alarm_irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_irq_q <= 1'b0;
    end else begin
      alarm_irq_q <= alarm_irq_d;
    end
  end

  assign alarm_irq = alarm_irq_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_en, alarm_hour, alarm_min, alarm_clr};
  assign alarm_irq    = 1'b0;
`endif

  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign sec_tick  = sec_tick_q;
  assign min_tick  = min_tick_q;
  assign hour_tick = hour_tick_q;
  assign day_tick  = day_tick_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// tb_rtc_calendar
// Directed bench for rtc_calendar with TICKS_PER_SEC = 4, so one second is
// four clk cycles. Expected values are hand-computed calendar results.
// Alarm expectations follow RTC_ALARM_EN: set when defined, always 0 otherwise.
module tb_rtc_calendar;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       set_valid;
  logic [5:0] set_sec;
  logic [5:0] set_min;
  logic [4:0] set_hour;
  logic [4:0] set_day;
  logic [3:0] set_month;
  logic [6:0] set_year;
  logic       set_err;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       sec_tick;
  logic       min_tick;
  logic       hour_tick;
  logic       day_tick;
  logic       alarm_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_clr;
  logic       alarm_irq;

  int checkCount;
  int passCount;

`ifdef RTC_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  rtc_calendar #(.TICKS_PER_SEC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .set_valid  (set_valid),
    .set_sec    (set_sec),
    .set_min    (set_min),
    .set_hour   (set_hour),
    .set_day    (set_day),
    .set_month  (set_month),
    .set_year   (set_year),
    .set_err    (set_err),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .day        (day),
    .month      (month),
    .year       (year),
    .sec_tick   (sec_tick),
    .min_tick   (min_tick),
    .hour_tick  (hour_tick),
    .day_tick   (day_tick),
    .alarm_en   (alarm_en),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_clr  (alarm_clr),
    .alarm_irq  (alarm_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a load for exactly one edge; outputs after return show its effect.
  task automatic applyStimulus(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                               input logic [4:0] d, input logic [3:0] mo, input logic [6:0] y);
    set_sec   = s;
    set_min   = m;
    set_hour  = h;
    set_day   = d;
    set_month = mo;
    set_year  = y;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  task automatic checkTime(input string tag, input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                           input logic [4:0] d, input logic [3:0] mo, input logic [6:0] y);
    checkOutput({tag, ".sec"},   sec,   s);
    checkOutput({tag, ".min"},   min,   m);
    checkOutput({tag, ".hour"},  hour,  h);
    checkOutput({tag, ".day"},   day,   d);
    checkOutput({tag, ".month"}, month, mo);
    checkOutput({tag, ".year"},  year,  y);
  endtask

  task automatic checkTicks(input string tag, input logic [3:0] expTicks);
    checkOutput({tag, ".ticks"}, {day_tick, hour_tick, min_tick, sec_tick}, expTicks);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    run        = 1'b0;
    set_valid  = 1'b0;
    set_sec    = '0;
    set_min    = '0;
    set_hour   = '0;
    set_day    = '0;
    set_month  = '0;
    set_year   = '0;
    alarm_en   = 1'b0;
    alarm_hour = '0;
    alarm_min  = '0;
    alarm_clr  = 1'b0;

    // Reset state
    #12;
    checkTime("reset", 0, 0, 0, 1, 1, 0);
    checkTicks("reset", 4'b0000);
    checkOutput("reset.set_err", set_err, 0);
    checkOutput("reset.irq", alarm_irq, 0);
    rst_n = 1'b1;
    run   = 1'b1;

    // Prescaler: first sec_tick after the 4th edge, then every 4 edges
    repeat (3) step();
    checkOutput("presc.sec3", sec, 0);
    checkTicks("presc.t3", 4'b0000);
    step();
    checkOutput("presc.sec4", sec, 1);
    checkTicks("presc.t4", 4'b0001);
    step();
    checkTicks("presc.t5", 4'b0000);
    repeat (2) step();
    checkOutput("presc.sec7", sec, 1);
    step();
    checkOutput("presc.sec8", sec, 2);
    checkTicks("presc.t8", 4'b0001);

    // Full rollover 2099-12-31 23:59:59 -> 2000-01-01 00:00:00
    applyStimulus(59, 59, 23, 31, 12, 99);
    checkTime("load99", 59, 59, 23, 31, 12, 99);
    checkTicks("load99", 4'b0000);
    repeat (3) step();
    checkOutput("roll.pre", sec, 59);
    step();
    checkTime("roll", 0, 0, 0, 1, 1, 0);
    checkTicks("roll", 4'b1111);
    step();
    checkTicks("roll.after", 4'b0000);

    // Leap year 2024: Feb 28 -> Feb 29
    applyStimulus(59, 59, 23, 28, 2, 24);
    repeat (4) step();
    checkTime("leap24", 0, 0, 0, 29, 2, 24);
    checkTicks("leap24", 4'b1111);

    // Non-leap 2023: Feb 28 -> Mar 1
    applyStimulus(59, 59, 23, 28, 2, 23);
    repeat (4) step();
    checkTime("leap23", 0, 0, 0, 1, 3, 23);

    // Feb 29 2023 rejected, then a valid load back-to-back
    applyStimulus(10, 10, 10, 29, 2, 23);
    checkOutput("rej.set_err", set_err, 1);
    checkTime("rej", 0, 0, 0, 1, 3, 23);
    checkTicks("rej", 4'b0000);
    applyStimulus(0, 0, 12, 15, 6, 30);
    checkOutput("b2b.set_err", set_err, 0);
    checkTime("b2b", 0, 0, 12, 15, 6, 30);

    // Out-of-range fields rejected
    applyStimulus(60, 0, 0, 1, 1, 0);
    checkOutput("rej60.set_err", set_err, 1);
    step();
    checkOutput("rej60.clear", set_err, 0);
    checkOutput("rej60.sec", sec, 0);

    // Load coincides with terminal count: load wins, no sec_tick
    applyStimulus(0, 0, 12, 15, 6, 30);
    repeat (3) step();
    applyStimulus(10, 0, 12, 15, 6, 30);
    checkOutput("lvt.sec", sec, 10);
    checkTicks("lvt", 4'b0000);
    repeat (3) step();
    checkOutput("lvt.sec3", sec, 10);
    step();
    checkOutput("lvt.sec4", sec, 11);
    checkTicks("lvt.t4", 4'b0001);

    // run=0 freezes mid-second and resumes from the held count
    applyStimulus(20, 0, 12, 15, 6, 30);
    step();
    run = 1'b0;
    repeat (6) step();
    checkOutput("hold.sec", sec, 20);
    run = 1'b1;
    repeat (2) step();
    checkOutput("resume.sec2", sec, 20);
    step();
    checkOutput("resume.sec3", sec, 21);

    // Alarm at 07:30
    alarm_en   = 1'b1;
    alarm_hour = 5'd7;
    alarm_min  = 6'd30;
    applyStimulus(59, 29, 7, 10, 5, 24);
    checkOutput("alarm.idle", alarm_irq, 0);
    repeat (4) step();
    checkTime("alarm", 0, 30, 7, 10, 5, 24);
    checkTicks("alarm", 4'b0011);
    checkOutput("alarm.set", alarm_irq, ALARM_ON);
    repeat (2) step();
    checkOutput("alarm.sticky", alarm_irq, ALARM_ON);
    applyStimulus(59, 29, 7, 10, 5, 24);
    repeat (3) step();
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    checkOutput("alarm.setwins", alarm_irq, ALARM_ON);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    checkOutput("alarm.clr", alarm_irq, 0);
    applyStimulus(0, 30, 7, 10, 5, 24);
    checkOutput("alarm.loadmatch", alarm_irq, 0);

    // Set the alarm again so reset has a live flag to clear
    applyStimulus(59, 29, 7, 10, 5, 24);
    repeat (4) step();
    checkOutput("alarm.again", alarm_irq, ALARM_ON);

    // Asynchronous reset mid-second with sec=5
    applyStimulus(5, 0, 10, 3, 4, 25);
    repeat (2) step();
    checkOutput("arst.pre", sec, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checkTime("arst", 0, 0, 0, 1, 1, 0);
    checkTicks("arst", 4'b0000);
    checkOutput("arst.set_err", set_err, 0);
    checkOutput("arst.irq", alarm_irq, 0);
    #10;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
